scope_capture_events: RTL

Capture-sequencing stage that produces the 3-bit event vector read by the Nios through the event PIO. It watches the ADC sample stream against a programmable trigger level and writes samples into the circular capture RAM. It runs an arm / pre-trigger / wait-for-trigger / post-trigger / done sequence. Event bits are sticky levels, so a polled, non-edge-capturing PIO never misses them.

---
 rtl/scope_capture_events.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/scope_capture_events.sv
// Capture sequencer: streams ADC samples into the circular capture RAM around a
// level-crossing (or forced) trigger and reports sticky ARMED/TRIGGERED/DONE events.
module scope_capture_events #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_falling,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [2:0]        event_out
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] pre_cnt_reg;
    logic [ADDR_W-1:0] post_cnt_reg;
    logic [ADDR_W-1:0] pre_len_reg;
    logic [ADDR_W-1:0] post_len_reg;
    logic [DATA_W-1:0] prev_reg;
    logic              prev_valid_reg;
    logic              force_pend_reg;
    logic              ev_trig_reg;
    logic              ev_done_reg;

    logic capturing;
    logic accept;
    logic level_hit;
    logic trig_hit;
    logic pre_last;
    logic post_last;

    // arm/abort take the cycle: a sample arriving with either is not written.
    always_comb begin
        capturing = (state_reg == ST_PRE) || (state_reg == ST_WAIT) || (state_reg == ST_POST);
        accept    = sample_valid && capturing && !arm && !abort;
        if (trig_falling)
            level_hit = (prev_reg > trig_level) && (sample <= trig_level);
        else
            level_hit = (prev_reg < trig_level) && (sample >= trig_level);
        trig_hit  = accept && (state_reg == ST_WAIT) &&
                    ((prev_valid_reg && level_hit) || force_pend_reg || force_trig);
        pre_last  = (pre_cnt_reg + ONE) == pre_len_reg;
        post_last = (post_cnt_reg + ONE) == post_len_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            pre_cnt_reg    <= '0;
            post_cnt_reg   <= '0;
            pre_len_reg    <= '0;
            post_len_reg   <= '0;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            force_pend_reg <= 1'b0;
            ev_trig_reg    <= 1'b0;
            ev_done_reg    <= 1'b0;
            buf_we         <= 1'b0;
            buf_addr       <= '0;
            buf_data       <= '0;
            trig_addr      <= '0;
        end else begin
            buf_we <= accept;
            if (accept) begin
                buf_addr       <= wr_ptr_reg;
                buf_data       <= sample;
                wr_ptr_reg     <= wr_ptr_reg + ONE;
                prev_reg       <= sample;
                prev_valid_reg <= 1'b1;
            end

            if (abort) begin
                state_reg      <= ST_IDLE;
                ev_trig_reg    <= 1'b0;
                ev_done_reg    <= 1'b0;
                force_pend_reg <= 1'b0;
            end else if (arm) begin
                state_reg      <= (pretrig_len == '0) ? ST_WAIT : ST_PRE;
                wr_ptr_reg     <= '0;
                pre_cnt_reg    <= '0;
                post_cnt_reg   <= '0;
                pre_len_reg    <= pretrig_len;
                post_len_reg   <= post_len;
                prev_valid_reg <= 1'b0;
                force_pend_reg <= 1'b0;
                ev_trig_reg    <= 1'b0;
                ev_done_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    ST_PRE: begin
                        if (accept) begin
                            pre_cnt_reg <= pre_cnt_reg + ONE;
                            if (pre_last)
                                state_reg <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (force_trig)
                            force_pend_reg <= 1'b1;
                        if (trig_hit) begin
                            force_pend_reg <= 1'b0;
                            trig_addr      <= wr_ptr_reg;
                            ev_trig_reg    <= 1'b1;
                            if (post_len_reg == '0) begin
                                state_reg   <= ST_DONE;
                                ev_done_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (accept) begin
                            post_cnt_reg <= post_cnt_reg + ONE;
                            if (post_last) begin
                                state_reg   <= ST_DONE;
                                ev_done_reg <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign event_out = {ev_done_reg, ev_trig_reg,
                        (state_reg == ST_PRE) || (state_reg == ST_WAIT)};

endmodule
